// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  localparam int REG_AW_DEF = 5;
  localparam int X0_ADDR    = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// 16-bit saturating wait counter; expire flags the last legal MEM_WAIT cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [15:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && cnt_reg != 16'hFFFF) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign expire = (cnt_reg == 16'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, MEM-stage branch, dmem wait.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REG_AW-1:0] ifid_rs1_i,
  input  logic [REG_AW-1:0] ifid_rs2_i,
  input  logic              idex_mem_rd_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              exmem_mem_rd_i,
  input  logic              exmem_mem_wr_i,
  input  logic              exmem_branch_i,
  input  logic              exmem_zero_i,
  input  logic              dmem_ready_i,
  output logic              dmem_req_o,
  output logic              pipe_en_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              pc_sel_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              exmem_flush_o,
  output logic              err_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o
`endif
);

  ctrl_state_t state_reg;
  logic        err_reg;
  logic        active_reg;
  logic        mem_op, branch_taken, load_use;
  logic        pipe_en, tmr_inc, tmr_clr, tmr_expire;

  assign mem_op       = exmem_mem_rd_i | exmem_mem_wr_i;
  assign branch_taken = exmem_branch_i & exmem_zero_i;
  assign load_use     = idex_mem_rd_i && (idex_rd_i != REG_AW'(X0_ADDR)) &&
                        ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expire  (tmr_expire)
  );

  // active_reg holds every output low until the first edge after reset release.
  always_comb begin
    dmem_req_o = 1'b0;
    pipe_en    = 1'b0;
    tmr_inc    = 1'b0;
    tmr_clr    = 1'b0;
    if (active_reg) begin
      case (state_reg)
        RUN: begin
          dmem_req_o = mem_op;
          pipe_en    = !mem_op || dmem_ready_i;
          tmr_inc    = mem_op && !dmem_ready_i;
        end
        MEM_WAIT: begin
          dmem_req_o = mem_op;
          pipe_en    = dmem_ready_i;
          tmr_clr    = dmem_ready_i;
          tmr_inc    = !dmem_ready_i && !tmr_expire;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg  <= RUN;
      err_reg    <= 1'b0;
      active_reg <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      if (active_reg) begin
        case (state_reg)
          RUN: if (mem_op && !dmem_ready_i) state_reg <= MEM_WAIT;
          MEM_WAIT: begin
            if (dmem_ready_i) begin
              state_reg <= RUN;
            end else if (tmr_expire) begin
              state_reg <= ERROR;
              err_reg   <= 1'b1;
            end
          end
          default: begin
            state_reg <= ERROR;
            err_reg   <= 1'b1;
          end
        endcase
      end
    end
  end

  // A taken branch squashes the younger instructions, so it masks load-use.
  always_comb begin
    pc_write_o    = active_reg;
    ifid_write_o  = active_reg;
    pc_sel_o      = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    if (pipe_en) begin
      if (branch_taken) begin
        pc_sel_o      = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end else if (load_use) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
      end
    end
  end

  assign pipe_en_o = pipe_en;
  assign err_o     = err_reg;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg, flush_cnt_reg;
  logic        stall_evt, flush_evt;

  assign stall_evt = active_reg &&
                     ((state_reg != RUN && !pipe_en) || (pipe_en && !branch_taken && load_use));
  assign flush_evt = pipe_en && branch_taken;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_evt && stall_cnt_reg != 32'hFFFF_FFFF) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (flush_evt && flush_cnt_reg != 32'hFFFF_FFFF) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_o = stall_cnt_reg;
  assign perf_flush_o = flush_cnt_reg;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipelined CPU.
- Gates the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables.
- Detects load-use hazards and redirects on taken branches resolved in MEM (EX/MEM Branch and Zero).
- Sequences the data-memory request/ready handshake, freezing the whole pipeline while memory is busy, with a watchdog timeout.

Parameters:
- REG_AW, 5: register address width.
- MEM_TIMEOUT, 64: maximum MEM_WAIT cycles before ERROR; legal range 2..65535.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- ifid_rs1_i  in  REG_AW  rs1 of the instruction in ID.
- ifid_rs2_i  in  REG_AW  rs2 of the instruction in ID.
- idex_mem_rd_i  in  1  ID/EX MemRead.
- idex_rd_i  in  REG_AW  ID/EX destination register.
- exmem_mem_rd_i  in  1  EX/MEM MemRead.
- exmem_mem_wr_i  in  1  EX/MEM MemWrite.
- exmem_branch_i  in  1  EX/MEM Branch.
- exmem_zero_i  in  1  EX/MEM Zero.
- dmem_ready_i  in  1  data memory completes the current access this cycle.
- dmem_req_o  out  1  data memory request.
- pipe_en_o  out  1  global enable for PC and all four pipeline registers.
- pc_write_o  out  1  PC write enable (qualified by pipe_en_o).
- ifid_write_o  out  1  IF/ID write enable (qualified by pipe_en_o).
- pc_sel_o  out  1  1 selects branch target (EX/MEM AddResult).
- ifid_flush_o  out  1  zero IF/ID on next edge.
- idex_flush_o  out  1  zero ID/EX control bits on next edge.
- exmem_flush_o  out  1  zero EX/MEM control bits on next edge.
- err_o  out  1  sticky memory-timeout error.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_n_i is asynchronous, active-low.
- Reset state while rst_n_i=0:
  - state=RUN, wait_cnt=0, err_o=0.
  - All outputs 0, including pipe_en_o and pc_write_o.
  - All outputs resume the cycle after deassertion.
  - Reset asserted in MEM_WAIT or ERROR abandons the access; dmem_req_o drops immediately (asynchronously).
- FSM: RUN, MEM_WAIT, ERROR. Outputs are Mealy, combinational from state and inputs, except err_o, which is registered.
- mem_op = exmem_mem_rd_i | exmem_mem_wr_i; dmem_req_o = mem_op in RUN and MEM_WAIT, else 0.
- RUN:
  - mem_op & dmem_ready_i: zero-wait access, pipe_en_o=1.
  - mem_op & !dmem_ready_i: pipe_en_o=0; next state MEM_WAIT, wait_cnt<=1.
- MEM_WAIT:
  - pipe_en_o=0; dmem_req_o held at 1 (EX/MEM inputs are frozen, so mem_op is stable).
  - dmem_ready_i=1: pipe_en_o=1 this cycle; next state RUN, wait_cnt<=0.
  - Else, if wait_cnt==MEM_TIMEOUT-1: next state ERROR, err_o<=1.
  - Else wait_cnt<=wait_cnt+1.
- ERROR: pipe_en_o=0, dmem_req_o=0, err_o=1. Exited only by reset.
- Priorities, evaluated only when pipe_en_o=1 (when pipe_en_o=0 all flushes=0, pc_sel_o=0, pc_write_o=ifid_write_o=1 but ineffective):
  - 1. Branch taken (exmem_branch_i & exmem_zero_i): pc_sel_o=1, ifid_flush_o=idex_flush_o=exmem_flush_o=1, pc_write_o=1; load-use is suppressed (the younger instructions are being squashed).
  - 2. Load-use: idex_mem_rd_i & idex_rd_i!=0 & (idex_rd_i==ifid_rs1_i | idex_rd_i==ifid_rs2_i) gives pc_write_o=0, ifid_write_o=0, idex_flush_o=1. Exactly one bubble per hazard; the next cycle, the load is in EX/MEM and the hazard clears.
  - 3. Otherwise: pc_write_o=ifid_write_o=1, no flush.
- A branch with a simultaneous mem_op (illegal encoding) is treated as a memory access first: the branch is applied in the cycle dmem_ready_i is seen.
- Register x0 never triggers a load-use stall.
- wait_cnt is 16 bits wide and saturates; it never wraps.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- With the macro:
  - Add outputs perf_stall_o[31:0] and perf_flush_o[31:0].
  - perf_stall_o counts cycles with pipe_en_o=0 in MEM_WAIT or ERROR, plus load-use bubbles.
  - perf_flush_o counts taken-branch flush events.
  - Both reset to 0, saturate at 0xFFFFFFFF and never wrap.
- Without the macro: ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - REG_AW default;
  - the x0 address constant.
- One natural sub-module, mem_wait_timer: a 16-bit saturating counter with clear/inc/expire for MEM_TIMEOUT, instantiated once.

Test Plan:
- Reset: drive rst_n_i=0 mid-MEM_WAIT with mem_op=1 -> dmem_req_o=0 and pipe_en_o=0 immediately; after release, state RUN and err_o=0.
- Zero-wait store: exmem_mem_wr_i=1, dmem_ready_i=1 -> dmem_req_o=1, pipe_en_o=1, no MEM_WAIT entry.
- Three-cycle load: exmem_mem_rd_i=1, ready low for 3 cycles then high -> pipe_en_o=0 for exactly 3 cycles, 1 on the ready cycle, then RUN.
- Load-use: idex_mem_rd_i=1, idex_rd_i=5, ifid_rs2_i=5 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_flush_o=1. Same with idex_rd_i=0 -> no stall.
- Branch vs load-use: exmem_branch_i=exmem_zero_i=1 plus a load-use hazard in the same cycle -> pc_sel_o=1, all three flushes=1, pc_write_o=1, no load-use stall.
- Timeout: MEM_TIMEOUT=4, ready never asserted -> ERROR entered after 4 stall cycles, err_o=1 sticky, dmem_req_o=0. With PIPE_HAZARD_PERF_EN, perf_stall_o keeps counting.
